// File: rtl/axi_xbar_map_cfg_if.sv
// Per-slave-port handshake observation and Ax stall lines between the crossbar and its map controller.
interface axi_xbar_map_cfg_if #(
  parameter int unsigned NoSlvPorts = 4
);
  logic [NoSlvPorts-1:0] aw_hs;
  logic [NoSlvPorts-1:0] ar_hs;
  logic [NoSlvPorts-1:0] b_hs;
  logic [NoSlvPorts-1:0] rlast_hs;
  logic [NoSlvPorts-1:0] aw_stall;
  logic [NoSlvPorts-1:0] ar_stall;

  modport master (output aw_hs, ar_hs, b_hs, rlast_hs, input aw_stall, ar_stall);
  modport slave  (input aw_hs, ar_hs, b_hs, rlast_hs, output aw_stall, ar_stall);
endinterface

// File: rtl/axi_xbar_map_cfg.sv
// Shadow/active address map with drain-then-swap commit; also limits outstanding AW/AR per slave port.
// Commit completes two cycles after acceptance at best; stalls are driven from registers only.
module axi_xbar_map_cfg #(
  parameter int unsigned NoSlvPorts    = 4,
  parameter int unsigned NoMstPorts    = 4,
  parameter int unsigned NoAddrRules   = 8,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned MaxTrans      = 8,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned MstIdxW  = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1,
  localparam int unsigned SlvIdxW  = (NoSlvPorts > 1) ? $clog2(NoSlvPorts) : 1,
  localparam int unsigned RuleIdxW = (NoAddrRules > 1) ? $clog2(NoAddrRules) : 1,
  localparam int unsigned RuleW    = MstIdxW + 2 * AddrWidth,
  localparam int unsigned CntW     = $clog2(MaxTrans + 1),
  localparam int unsigned TmoW     = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  cfg_rule_we_i,
  input  logic [RuleIdxW-1:0]                   cfg_rule_idx_i,
  input  logic [RuleW-1:0]                      cfg_rule_i,
  input  logic                                  cfg_dflt_we_i,
  input  logic [SlvIdxW-1:0]                    cfg_dflt_port_i,
  input  logic                                  cfg_dflt_en_i,
  input  logic [MstIdxW-1:0]                    cfg_dflt_idx_i,
  input  logic                                  cfg_commit_i,
  output logic                                  cfg_ready_o,
  output logic                                  commit_done_o,
  output logic                                  commit_err_o,
  axi_xbar_map_cfg_if.slave                     mon,
  output logic                                  cnt_err_o,
  output logic [NoAddrRules-1:0][RuleW-1:0]     addr_map_o,
  output logic [NoSlvPorts-1:0]                 en_default_mst_port_o,
  output logic [NoSlvPorts-1:0][MstIdxW-1:0]    default_mst_port_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDrain  = 2'd1;
  localparam logic [1:0] StCommit = 2'd2;

  logic [1:0]                              state_q;
  logic [TmoW-1:0]                         tmo_q;
  logic                                    err_q;
  logic                                    cnt_err_q;
  logic [NoAddrRules-1:0][RuleW-1:0]       shd_map_q, act_map_q;
  logic [NoSlvPorts-1:0]                   shd_en_q, act_en_q;
  logic [NoSlvPorts-1:0][MstIdxW-1:0]      shd_idx_q, act_idx_q;
  logic [CntW-1:0]                         wcnt_q [NoSlvPorts];
  logic [CntW-1:0]                         rcnt_q [NoSlvPorts];
  logic [CntW:0]                           w_upd  [NoSlvPorts];
  logic [CntW:0]                           r_upd  [NoSlvPorts];
  logic                                    cnt_err_hit;
  logic                                    all_idle;
  logic                                    stalled;

  // Returns {error, next_count}; out-of-range moves hold the count and flag an error.
  function automatic logic [CntW:0] cnt_upd(input logic [CntW-1:0] c, input logic inc, input logic dec);
    logic [CntW:0] r;
    r = {1'b0, c};
    if (inc && !dec) begin
      if (c == CntW'(MaxTrans)) r[CntW] = 1'b1;
      else                      r = {1'b0, c + CntW'(1)};
    end else if (dec && !inc) begin
      if (c == '0) r[CntW] = 1'b1;
      else         r = {1'b0, c - CntW'(1)};
    end
    return r;
  endfunction

  always_comb begin
    cnt_err_hit = 1'b0;
    all_idle    = 1'b1;
    for (int i = 0; i < NoSlvPorts; i++) begin
      w_upd[i]    = cnt_upd(wcnt_q[i], mon.aw_hs[i], mon.b_hs[i]);
      r_upd[i]    = cnt_upd(rcnt_q[i], mon.ar_hs[i], mon.rlast_hs[i]);
      cnt_err_hit = cnt_err_hit | w_upd[i][CntW] | r_upd[i][CntW];
      all_idle    = all_idle && (wcnt_q[i] == '0) && (rcnt_q[i] == '0);
    end
  end

  assign stalled = (state_q != StIdle);

  always_comb begin
    mon.aw_stall = '0;
    mon.ar_stall = '0;
    for (int i = 0; i < NoSlvPorts; i++) begin
      mon.aw_stall[i] = stalled || (wcnt_q[i] == CntW'(MaxTrans));
      mon.ar_stall[i] = stalled || (rcnt_q[i] == CntW'(MaxTrans));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      cnt_err_q <= 1'b0;
      shd_map_q <= '0;
      act_map_q <= '0;
      shd_en_q  <= '0;
      act_en_q  <= '0;
      shd_idx_q <= '0;
      act_idx_q <= '0;
      for (int i = 0; i < NoSlvPorts; i++) begin
        wcnt_q[i] <= '0;
        rcnt_q[i] <= '0;
      end
    end else begin
      err_q     <= 1'b0;
      cnt_err_q <= cnt_err_q | cnt_err_hit;
      for (int i = 0; i < NoSlvPorts; i++) begin
        wcnt_q[i] <= w_upd[i][CntW-1:0];
        rcnt_q[i] <= r_upd[i][CntW-1:0];
      end
      case (state_q)
        StIdle: begin
          if (cfg_rule_we_i) shd_map_q[cfg_rule_idx_i] <= cfg_rule_i;
          if (cfg_dflt_we_i) begin
            shd_en_q[cfg_dflt_port_i]  <= cfg_dflt_en_i;
            shd_idx_q[cfg_dflt_port_i] <= cfg_dflt_idx_i;
          end
          if (cfg_commit_i) begin
            state_q <= StDrain;
            tmo_q   <= '0;
          end
        end
        StDrain: begin
          tmo_q <= tmo_q + TmoW'(1);
          // A drain that completes on the last allowed cycle still commits.
          if (all_idle) begin
            state_q   <= StCommit;
            act_map_q <= shd_map_q;
            act_en_q  <= shd_en_q;
            act_idx_q <= shd_idx_q;
          end else if ((TimeoutCycles != 0) && (tmo_q == TmoW'(TimeoutCycles - 1))) begin
            state_q <= StIdle;
            err_q   <= 1'b1;
          end
        end
        StCommit: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign cfg_ready_o           = (state_q == StIdle);
  assign commit_done_o         = (state_q == StCommit);
  assign commit_err_o          = err_q;
  assign cnt_err_o             = cnt_err_q;
  assign addr_map_o            = act_map_q;
  assign en_default_mst_port_o = act_en_q;
  assign default_mst_port_o    = act_idx_q;

endmodule

// File: tb/tb_axi_xbar_map_cfg.sv
// Bench for axi_xbar_map_cfg: every cycle is checked against a behavioural model, plus directed corner cases.
module tb_axi_xbar_map_cfg;
  localparam int NS = 4, NM = 4, NR = 8, AW = 32, MAXT = 3, TMO = 16;
  localparam int MI = 2, SI = 2, RI = 3, RW = MI + 2 * AW;

  logic clk = 1'b0;
  logic rst, rule_we, dflt_we, dflt_en, commit;
  logic [RI-1:0] rule_idx;
  logic [RW-1:0] rule;
  logic [SI-1:0] dflt_port;
  logic [MI-1:0] dflt_idx;
  logic cfg_ready, done, err, cnt_err;
  logic [NR-1:0][RW-1:0] addr_map;
  logic [NS-1:0] en_dflt;
  logic [NS-1:0][MI-1:0] dflt_mst;

  axi_xbar_map_cfg_if #(.NoSlvPorts(NS)) bus ();

  axi_xbar_map_cfg #(
    .NoSlvPorts(NS), .NoMstPorts(NM), .NoAddrRules(NR), .AddrWidth(AW),
    .MaxTrans(MAXT), .TimeoutCycles(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_rule_we_i(rule_we), .cfg_rule_idx_i(rule_idx), .cfg_rule_i(rule),
    .cfg_dflt_we_i(dflt_we), .cfg_dflt_port_i(dflt_port), .cfg_dflt_en_i(dflt_en),
    .cfg_dflt_idx_i(dflt_idx), .cfg_commit_i(commit),
    .cfg_ready_o(cfg_ready), .commit_done_o(done), .commit_err_o(err),
    .mon(bus), .cnt_err_o(cnt_err), .addr_map_o(addr_map),
    .en_default_mst_port_o(en_dflt), .default_mst_port_o(dflt_mst)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  string phase = "init";

  // Behavioural model: phase 0 idle, 1 draining, 2 committing.
  int m_st, m_drain_cycles, m_w[NS], m_r[NS], m_shd_ix[NS], m_act_ix[NS];
  bit m_err, m_cerr, m_shd_en[NS], m_act_en[NS];
  logic [RW-1:0] m_shd[NR], m_act[NR];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s/%s got=%0h want=%0h", phase, nm, act, exp);
    end
  endtask

  task automatic model_step();
    bit busy = 1'b0;
    int n;
    if (rst) begin
      m_st = 0; m_drain_cycles = 0; m_err = 0; m_cerr = 0;
      for (int i = 0; i < NS; i++) begin
        m_w[i] = 0; m_r[i] = 0; m_shd_en[i] = 0; m_act_en[i] = 0; m_shd_ix[i] = 0; m_act_ix[i] = 0;
      end
      for (int i = 0; i < NR; i++) begin m_shd[i] = '0; m_act[i] = '0; end
      return;
    end
    for (int i = 0; i < NS; i++) if (m_w[i] != 0 || m_r[i] != 0) busy = 1'b1;
    m_err = 0;
    if (m_st == 0) begin
      if (rule_we) m_shd[rule_idx] = rule;
      if (dflt_we) begin m_shd_en[dflt_port] = dflt_en; m_shd_ix[dflt_port] = int'(dflt_idx); end
      if (commit) begin m_st = 1; m_drain_cycles = 0; end
    end else if (m_st == 1) begin
      m_drain_cycles++;
      if (!busy) begin
        m_st = 2; m_act = m_shd; m_act_en = m_shd_en; m_act_ix = m_shd_ix;
      end else if (m_drain_cycles == TMO) begin
        m_st = 0; m_err = 1;
      end
    end else m_st = 0;
    for (int i = 0; i < NS; i++) begin
      n = m_w[i] + int'(bus.aw_hs[i]) - int'(bus.b_hs[i]);
      if (n < 0) begin n = 0; m_cerr = 1; end
      if (n > MAXT) begin n = MAXT; m_cerr = 1; end
      m_w[i] = n;
      n = m_r[i] + int'(bus.ar_hs[i]) - int'(bus.rlast_hs[i]);
      if (n < 0) begin n = 0; m_cerr = 1; end
      if (n > MAXT) begin n = MAXT; m_cerr = 1; end
      m_r[i] = n;
    end
  endtask

  task automatic compare_all();
    logic [NS-1:0] e_aws, e_ars, e_en;
    logic [NS-1:0][MI-1:0] e_ix;
    for (int i = 0; i < NS; i++) begin
      e_aws[i] = (m_st != 0) || (m_w[i] == MAXT);
      e_ars[i] = (m_st != 0) || (m_r[i] == MAXT);
      e_en[i]  = m_act_en[i];
      e_ix[i]  = MI'(m_act_ix[i]);
    end
    chk("ready", cfg_ready, m_st == 0);
    chk("done", done, m_st == 2);
    chk("err", err, m_err);
    chk("cnt_err", cnt_err, m_cerr);
    chk("aw_stall", bus.aw_stall, e_aws);
    chk("ar_stall", bus.ar_stall, e_ars);
    chk("dflt_en", en_dflt, e_en);
    chk("dflt_idx", dflt_mst, e_ix);
    for (int i = 0; i < NR; i++) chk($sformatf("map%0d", i), addr_map[i], m_act[i]);
  endtask

  // One clock: DUT and model consume the same inputs, outputs compared #1 after the edge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    rst = 0; rule_we = 0; dflt_we = 0; commit = 0;
    bus.aw_hs = '0; bus.ar_hs = '0; bus.b_hs = '0; bus.rlast_hs = '0;
  endtask

  typedef struct { logic aw, b, ar, rl, e_aws, e_ars; } vec_t;
  vec_t tbl[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] r0, r1;
    tbl[0]  = '{0,0,1,0, 0,0};
    tbl[1]  = '{0,0,1,0, 0,0};
    tbl[2]  = '{0,0,1,0, 0,1};
    tbl[3]  = '{0,0,1,1, 0,1};
    tbl[4]  = '{0,0,0,1, 0,0};
    tbl[5]  = '{1,0,0,0, 0,0};
    tbl[6]  = '{1,0,0,0, 0,0};
    tbl[7]  = '{1,0,0,0, 1,0};
    tbl[8]  = '{1,1,0,0, 1,0};
    tbl[9]  = '{0,1,0,0, 0,0};
    tbl[10] = '{0,1,0,0, 0,0};
    tbl[11] = '{0,1,0,1, 0,0};
    tbl[12] = '{0,0,0,1, 0,0};
    tbl[13] = '{0,0,0,0, 0,0};

    rule_we = 0; dflt_we = 0; commit = 0; dflt_en = 0; rule_idx = '0; rule = '0;
    dflt_port = '0; dflt_idx = '0;
    bus.aw_hs = '0; bus.ar_hs = '0; bus.b_hs = '0; bus.rlast_hs = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    rst = 1;
    phase = "reset";
    cyc();
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_stall", {bus.aw_stall, bus.ar_stall}, 8'h00);
    chk("rst_map0", addr_map[0], '0);

    phase = "commit_min";
    r0 = {2'd2, 32'h0000_1000, 32'h0000_2000};
    rule_we = 1; rule_idx = 3'd0; rule = r0;
    cyc();
    commit = 1;
    cyc();
    chk("drain_stall", {bus.aw_stall, bus.ar_stall}, 8'hff);
    chk("drain_done", done, 1'b0);
    cyc();
    chk("done_t2", done, 1'b1);
    chk("map0_swapped", addr_map[0], r0);
    cyc();
    chk("stall_drop", {bus.aw_stall, bus.ar_stall}, 8'h00);

    phase = "drain_port1";
    for (int k = 0; k < 3; k++) begin bus.aw_hs[1] = 1; cyc(); end
    commit = 1;
    cyc();
    chk("stall_all", {bus.aw_stall, bus.ar_stall}, 8'hff);
    for (int k = 0; k < 3; k++) begin bus.b_hs[1] = 1; cyc(); end
    chk("not_yet", done, 1'b0);
    cyc();
    chk("swap", done, 1'b1);
    chk("stall_in_commit", bus.aw_stall, 4'hf);
    cyc();
    chk("stall_after", bus.aw_stall, 4'h0);

    phase = "table";
    for (int i = 0; i < 14; i++) begin
      bus.aw_hs[0] = tbl[i].aw; bus.b_hs[0] = tbl[i].b;
      bus.ar_hs[0] = tbl[i].ar; bus.rlast_hs[0] = tbl[i].rl;
      cyc();
      chk($sformatf("v%0d_aws", i), bus.aw_stall[0], tbl[i].e_aws);
      chk($sformatf("v%0d_ars", i), bus.ar_stall[0], tbl[i].e_ars);
    end

    phase = "timeout";
    r1 = {2'd1, 32'h0000_4000, 32'h0000_4fff};
    bus.aw_hs[2] = 1;
    cyc();
    rule_we = 1; rule_idx = 3'd1; rule = r1; commit = 1;
    cyc();
    repeat (15) cyc();
    chk("no_err_yet", err, 1'b0);
    chk("still_stalled", bus.aw_stall, 4'hf);
    cyc();
    chk("err_pulse", err, 1'b1);
    chk("err_stall_drop", bus.aw_stall, 4'h0);
    chk("map1_kept", addr_map[1], '0);
    cyc();
    chk("err_one_cycle", err, 1'b0);
    bus.b_hs[2] = 1;
    cyc();
    commit = 1;
    cyc();
    cyc();
    chk("recommit_done", done, 1'b1);
    chk("map1_shadow_kept", addr_map[1], r1);

    phase = "dflt_drain";
    bus.aw_hs[3] = 1;
    cyc();
    commit = 1;
    cyc();
    chk("ready_low", cfg_ready, 1'b0);
    dflt_we = 1; dflt_port = 2'd3; dflt_en = 1; dflt_idx = 2'd3;
    cyc();
    bus.b_hs[3] = 1;
    cyc();
    cyc();
    chk("dflt_done", done, 1'b1);
    chk("dflt_en_unchanged", en_dflt[3], 1'b0);
    chk("dflt_idx_unchanged", dflt_mst[3], 2'd0);

    phase = "random";
    for (int c = 0; c < 800; c++) begin
      for (int p = 0; p < NS; p++) begin
        bus.aw_hs[p]    = (m_st == 0) && (m_w[p] < MAXT) && ($urandom_range(2) == 0);
        bus.ar_hs[p]    = (m_st == 0) && (m_r[p] < MAXT) && ($urandom_range(2) == 0);
        bus.b_hs[p]     = (m_w[p] > 0) && ($urandom_range(2) == 0);
        bus.rlast_hs[p] = (m_r[p] > 0) && ($urandom_range(2) == 0);
      end
      rule_we   = ($urandom_range(7) == 0);
      rule_idx  = RI'($urandom);
      rule      = RW'({$urandom, $urandom, $urandom});
      dflt_we   = ($urandom_range(7) == 0);
      dflt_port = SI'($urandom);
      dflt_en   = 1'($urandom);
      dflt_idx  = MI'($urandom);
      commit    = ($urandom_range(15) == 0);
      cyc();
    end

    phase = "cnt_err";
    rst = 1;
    cyc();
    bus.b_hs[0] = 1;
    cyc();
    chk("underflow_err", cnt_err, 1'b1);
    repeat (3) cyc();
    chk("err_sticky", cnt_err, 1'b1);
    chk("cnt_stays_zero", bus.aw_stall[0], 1'b0);
    rst = 1;
    cyc();
    chk("err_cleared", cnt_err, 1'b0);
    for (int k = 0; k < 4; k++) begin bus.aw_hs[1] = 1; cyc(); end
    chk("overflow_err", cnt_err, 1'b1);
    chk("sat_stall", bus.aw_stall[1], 1'b1);
    bus.b_hs[1] = 1;
    cyc();
    chk("sat_at_max", bus.aw_stall[1], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
